conv_acc_writer: RTL



---
 rtl/conv_acc_writer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/conv_acc_writer.sv
`default_nettype none
// ============================================================================
// conv_acc_writer: accumulates 2x2 partial sums over CH_NUM channels, adds
// bias, rounds, applies ReLU/saturation and writes one packed SRAM word.
// Revision 1.0
// ============================================================================
module conv_acc_writer #(
   parameter int CH_NUM       = 24,
   parameter int ACT_PER_ADDR = 4,
   parameter int BW_PER_ACT   = 16,
   parameter int SUM_BW       = 32,
   parameter int ACC_BW       = 40,
   parameter int BW_PER_BIAS  = 8,
   parameter int BIAS_SHIFT   = 7,
   parameter int FRAC_SHIFT   = 7,
   parameter int ADDR_BW      = 10,
   parameter int NUM_WORDS    = 1024
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               relu_en,
   input  logic                               sum_valid,
   input  logic [SUM_BW-1:0]                  LU_sum,
   input  logic [SUM_BW-1:0]                  RU_sum,
   input  logic [SUM_BW-1:0]                  LD_sum,
   input  logic [SUM_BW-1:0]                  RD_sum,
   input  logic [BW_PER_BIAS-1:0]             bias,
   output logic                               sram_wen_n,
   output logic [ADDR_BW-1:0]                 sram_waddr,
   output logic [ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata,
   output logic                               busy,
   output logic                               done
);

   localparam int CNT_BW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam logic signed [ACC_BW-1:0] ROUND   = ACC_BW'(1) << (FRAC_SHIFT - 1);
   localparam logic signed [ACC_BW-1:0] SAT_MAX = ACC_BW'((1 << (BW_PER_ACT - 1)) - 1);
   localparam logic signed [ACC_BW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [CNT_BW-1:0]              ch_cnt;
   logic [ADDR_BW-1:0]             wr_addr;
   logic                           s1_valid;
   logic                           s1_relu;
   logic signed [SUM_BW-1:0]       lane_sum [ACT_PER_ADDR];
   logic [ACT_PER_ADDR*BW_PER_ACT-1:0] act_word;
   logic signed [ACC_BW-1:0]       bias_term;
   logic                           take;
   logic                           last_ch;
   logic                           finish;
   logic                           flush;

   // Lane order matches the packed word: lane 0 lands in the MSBs.
   assign lane_sum[0] = $signed(LU_sum);
   assign lane_sum[1] = $signed(RU_sum);
   assign lane_sum[2] = $signed(LD_sum);
   assign lane_sum[3] = $signed(RD_sum);

   assign bias_term = ACC_BW'($signed(bias)) <<< BIAS_SHIFT;
   assign last_ch   = (ch_cnt == CNT_BW'(CH_NUM - 1));
   assign take      = (state == ACTIVE) && sum_valid && !start;
   assign finish    = (state == ACTIVE) && !start && !sram_wen_n
                      && (sram_waddr == ADDR_BW'(NUM_WORDS - 1));
   // A restart or pass completion drops anything still in flight.
   assign flush     = start || finish;
   assign busy      = (state == ACTIVE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACTIVE;
         ACTIVE: begin
            if (start)       state_nxt = ACTIVE;
            else if (finish) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ch_cnt   <= '0;
         s1_valid <= 1'b0;
         s1_relu  <= 1'b0;
      end else if (flush) begin
         ch_cnt   <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= take && last_ch;
         if (take) begin
            ch_cnt <= last_ch ? '0 : ch_cnt + CNT_BW'(1);
            if (last_ch) s1_relu <= relu_en;
         end
      end
   end

   generate
      for (genvar i = 0; i < ACT_PER_ADDR; i++) begin : g_lane
         logic signed [ACC_BW-1:0] acc;
         logic signed [ACC_BW-1:0] fin;
         logic signed [ACC_BW-1:0] acc_nxt;
         logic signed [ACC_BW-1:0] rnd;
         logic [BW_PER_ACT-1:0]    act;

         assign acc_nxt = ((ch_cnt == '0) ? '0 : acc) + ACC_BW'(lane_sum[i]);
         assign rnd     = (fin + ROUND) >>> FRAC_SHIFT;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               acc <= '0;
               fin <= '0;
            end else if (take) begin
               acc <= acc_nxt;
               if (last_ch) fin <= acc_nxt + bias_term;
            end
         end

         always_comb begin
            act = rnd[BW_PER_ACT-1:0];
            if (s1_relu && rnd < 0) act = '0;
            else if (rnd > SAT_MAX) act = SAT_MAX[BW_PER_ACT-1:0];
            else if (rnd < SAT_MIN) act = SAT_MIN[BW_PER_ACT-1:0];
         end

         assign act_word[(ACT_PER_ADDR-1-i)*BW_PER_ACT +: BW_PER_ACT] = act;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sram_wen_n <= 1'b1;
         sram_waddr <= '0;
         sram_wdata <= '0;
         wr_addr    <= '0;
         done       <= 1'b0;
      end else begin
         done <= finish;
         if (flush) begin
            sram_wen_n <= 1'b1;
            wr_addr    <= '0;
         end else begin
            sram_wen_n <= !s1_valid;
            if (s1_valid) begin
               sram_waddr <= wr_addr;
               sram_wdata <= act_word;
               wr_addr    <= wr_addr + ADDR_BW'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire
